conv3x3_mac_stage: RTL

CONV3X3_MAC_STAGE -- requirements
Module: conv3x3_mac_stage

---
 rtl/conv3x3_mac_stage.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/conv3x3_mac_stage.sv
// 3x3 convolution MAC stage: nine-product multiply, adder-tree, registered output with
// raster position flags. Define CONV_ROUND_SAT_EN for round-half-up and saturation.
module conv3x3_mac_stage #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ROW_OUT  = 62,
  parameter int unsigned ROWS_OUT = 62,
  parameter int unsigned SHIFT    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            in_valid,
  output logic [2:0]            in_ready,
  input  logic [3*DATA_W-1:0]   row0_data,
  input  logic [3*DATA_W-1:0]   row1_data,
  input  logic [3*DATA_W-1:0]   row2_data,
  input  logic                  wt_wr_en,
  input  logic [3:0]            wt_addr,
  input  logic [DATA_W-1:0]     wt_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last_col,
  output logic                  out_last_frame
);

  localparam int unsigned TAPS   = 9;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = 2 * DATA_W + 4;
  localparam int unsigned COL_W  = (ROW_OUT > 1) ? $clog2(ROW_OUT) : 1;
  localparam int unsigned ROW_W  = (ROWS_OUT > 1) ? $clog2(ROWS_OUT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_OUT - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS_OUT - 1);

`ifdef CONV_ROUND_SAT_EN
  localparam int unsigned STG_W    = SUM_W;
  localparam int unsigned SHIFT_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [SUM_W-1:0] RND =
    (SHIFT > 0) ? (SUM_W'(1) << SHIFT_M1) : SUM_W'(0);
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`else
  localparam int unsigned STG_W = DATA_W;
`endif

  logic signed [DATA_W-1:0] weight [TAPS];
  logic signed [DATA_W-1:0] pix    [TAPS];
  logic signed [PROD_W-1:0] prod   [TAPS];
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  sum_rs;
  logic signed [STG_W-1:0]  sum_q;
  logic [DATA_W-1:0]        result;
  logic                     v1;
  logic                     v2;
  logic                     adv_out;
  logic                     adv1;
  logic                     accept;
  logic                     fire;
  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic [COL_W-1:0]         col_nxt;
  logic [ROW_W-1:0]         row_nxt;

  // Backpressure chain: a stage advances when its successor is empty or advancing.
  assign adv_out  = !out_valid || out_ready;
  assign adv1     = !v2 || adv_out;
  assign accept   = !v1 || adv1;
  assign fire     = rst_n & (&in_valid) & accept;
  assign in_ready = {3{fire}};

  // Window unpack: tap index = row*3 + col.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      pix[c]     = row0_data[c*DATA_W +: DATA_W];
      pix[3 + c] = row1_data[c*DATA_W +: DATA_W];
      pix[6 + c] = row2_data[c*DATA_W +: DATA_W];
    end
  end

  // Weight file; a write in a fire cycle only affects later fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) weight[i] <= '0;
    end else if (wt_wr_en && (wt_addr <= 4'd8)) begin
      weight[wt_addr] <= wt_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      for (int i = 0; i < TAPS; i++) prod[i] <= '0;
    end else if (accept) begin
      v1 <= fire;
      if (fire) begin
        for (int i = 0; i < TAPS; i++) prod[i] <= PROD_W'(pix[i]) * PROD_W'(weight[i]);
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < TAPS; i++) sum = sum + SUM_W'(prod[i]);
`ifdef CONV_ROUND_SAT_EN
    sum_rs = (sum + RND) >>> SHIFT;
`else
    sum_rs = sum >>> SHIFT;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      sum_q <= '0;
    end else if (adv1) begin
      v2 <= v1;
      if (v1) sum_q <= STG_W'(sum_rs);
    end
  end

  // Final narrowing: clamp to the signed output range, or plain wrap-around.
  always_comb begin
`ifdef CONV_ROUND_SAT_EN
    if (sum_q > SAT_MAX)      result = {1'b0, {(DATA_W-1){1'b1}}};
    else if (sum_q < SAT_MIN) result = {1'b1, {(DATA_W-1){1'b0}}};
    else                      result = sum_q[DATA_W-1:0];
`else
    result = sum_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv_out) begin
      out_valid <= v2;
      if (v2) out_data <= result;
    end
  end

  always_comb begin
    col_nxt = col + COL_W'(1);
    row_nxt = row;
    if (col == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
    end
  end

  // Position of the result currently presented; flags are precomputed for the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col            <= '0;
      row            <= '0;
      out_last_col   <= 1'(ROW_OUT == 1);
      out_last_frame <= 1'((ROW_OUT == 1) && (ROWS_OUT == 1));
    end else if (out_valid && out_ready) begin
      col            <= col_nxt;
      row            <= row_nxt;
      out_last_col   <= (col_nxt == COL_LAST);
      out_last_frame <= (col_nxt == COL_LAST) && (row_nxt == ROW_LAST);
    end
  end

endmodule
